// File: rtl/ahb_apb_pkg.sv
// Shared encodings and helpers for the AHB to APB3 bridge.
// Strobe helper is width-agnostic; callers slice the low bytes.
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HR_OKAY  = 2'b00,
    HR_ERROR = 2'b01
  } hresp_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WWAIT,
    S_SETUP,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_t;

  function automatic int max_size(
    input int data_w
  );
    return $clog2(data_w / 8);
  endfunction

  function automatic logic [7:0] strb_mask(
    input int size,
    input int off
  );
    logic [15:0] m;
    m = 16'((1 << (1 << size)) - 1) << off;
    return m[7:0];
  endfunction

endpackage

// File: rtl/ahb_apb3_bridge_if.sv
// AHB slave side and APB master side of the bridge.
// The slave modport is the bridge view; master is the bus owner view.
interface ahb_apb3_bridge_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = 4
);
  logic                  Hreadyin;
  logic [1:0]            Htrans;
  logic [2:0]            Hsize;
  logic                  Hwrite;
  logic [ADDR_W-1:0]     Haddr;
  logic [DATA_W-1:0]     Hwdata;
  logic [DATA_W-1:0]     Hrdata;
  logic                  Hreadyout;
  logic [1:0]            Hresp;
  logic [NUM_SLV-1:0]    Pselx;
  logic                  Penable;
  logic                  Pwrite;
  logic [ADDR_W-1:0]     Paddr;
  logic [DATA_W-1:0]     Pwdata;
  logic [DATA_W/8-1:0]   Pstrb;
  logic [DATA_W-1:0]     Prdata;
  logic                  Pready;
  logic                  Pslverr;

  modport slave (
    input  Hreadyin, Htrans, Hsize, Hwrite,
    input  Haddr, Hwdata,
    output Hrdata, Hreadyout, Hresp,
    output Pselx, Penable, Pwrite, Paddr,
    output Pwdata, Pstrb,
    input  Prdata, Pready, Pslverr
  );

  modport master (
    output Hreadyin, Htrans, Hsize, Hwrite,
    output Haddr, Hwdata,
    input  Hrdata, Hreadyout, Hresp,
    input  Pselx, Penable, Pwrite, Paddr,
    input  Pwdata, Pstrb,
    output Prdata, Pready, Pslverr
  );

endinterface

// File: rtl/apb_slot_decode.sv
// Address phase decode: slave slot, legality and byte strobes.
// Any address above the slot window counts as an unmapped slot.
module apb_slot_decode
  import ahb_apb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 24,
  localparam int SEL_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  output logic [SEL_W-1:0]  slot,
  output logic              legal,
  output logic [STRB_W-1:0] strb
);
  localparam int BL   = $clog2(STRB_W);
  localparam int HI_W = ADDR_W - SEL_LSB;

  logic [HI_W-1:0] hi;
  logic [7:0]      m;
  logic            in_range;
  logic            size_ok;
  logic            align_ok;
  logic            unused_bits;
  int              sz;
  int              off;

  assign hi   = addr[ADDR_W-1:SEL_LSB];
  assign slot = addr[SEL_LSB +: SEL_W];

  always_comb begin
    sz       = int'(size);
    off      = int'(addr[BL-1:0]);
    m        = strb_mask(sz, off);
    in_range = hi < HI_W'(NUM_SLV);
    size_ok  = sz <= max_size(DATA_W);
    align_ok = (off & ((1 << sz) - 1)) == 0;
    legal    = in_range && size_ok && align_ok;
    strb     = m[STRB_W-1:0];
  end

  assign unused_bits = ^{addr[SEL_LSB-1:BL], m};

endmodule

// File: rtl/ahb_apb3_bridge.sv
// AHB-Lite slave to APB3 master bridge, one transfer in flight.
// Errors, illegal transfers and slave errors use the 2-cycle response.
module ahb_apb3_bridge
  import ahb_apb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 24
) (
  input  logic              Hclk,
  input  logic              Hreset,
  ahb_apb3_bridge_if.slave  bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int SEL_W  =
    (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  state_t            state_q;
  state_t            state_d;
  logic [SEL_W-1:0]  slot_q;
  logic [SEL_W-1:0]  dec_slot;
  logic              dec_legal;
  logic [STRB_W-1:0] dec_strb;
  logic              accept;
  logic              rd_done;

  apb_slot_decode #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_SLV (NUM_SLV),
    .SEL_LSB (SEL_LSB)
  ) u_dec (
    .addr  (bus.Haddr),
    .size  (bus.Hsize),
    .slot  (dec_slot),
    .legal (dec_legal),
    .strb  (dec_strb)
  );

  assign accept = (state_q == S_IDLE)
               && bus.Hreadyin
               && (bus.Htrans == HT_NONSEQ
                || bus.Htrans == HT_SEQ);

  assign rd_done = (state_q == S_ACCESS)
                && bus.Pready
                && !bus.Pslverr
                && !bus.Pwrite;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!dec_legal)      state_d = S_ERR1;
          else if (bus.Hwrite) state_d = S_WWAIT;
          else                 state_d = S_SETUP;
        end
      end
      S_WWAIT:  state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (bus.Pready)
          state_d = bus.Pslverr ? S_ERR1 : S_IDLE;
      end
      S_ERR1:   state_d = S_ERR2;
      S_ERR2:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q    <= S_IDLE;
      slot_q     <= '0;
      bus.Paddr  <= '0;
      bus.Pwrite <= 1'b0;
      bus.Pstrb  <= '0;
      bus.Pwdata <= '0;
      bus.Hrdata <= '0;
    end else begin
      state_q <= state_d;
      // Illegal transfers never touch the APB side
      if (accept && dec_legal) begin
        slot_q     <= dec_slot;
        bus.Paddr  <= bus.Haddr;
        bus.Pwrite <= bus.Hwrite;
        bus.Pstrb  <= bus.Hwrite ? dec_strb : '0;
      end
      if (state_q == S_WWAIT)
        bus.Pwdata <= bus.Hwdata;
      if (rd_done)
        bus.Hrdata <= bus.Prdata;
    end
  end

  always_comb begin
    bus.Pselx = '0;
    if (state_q == S_SETUP || state_q == S_ACCESS)
      bus.Pselx[slot_q] = 1'b1;
  end

  assign bus.Penable   = (state_q == S_ACCESS);
  assign bus.Hreadyout = (state_q == S_IDLE)
                      || (state_q == S_ERR2);
  assign bus.Hresp     =
    (state_q == S_ERR1 || state_q == S_ERR2)
      ? HR_ERROR : HR_OKAY;

endmodule

// File: tb/tb_ahb_apb3_bridge.sv
// Directed plus randomized transfers against a transfer-level model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_ahb_apb3_bridge;

  logic Hclk = 1'b0;
  logic Hreset;

  always #5 Hclk = ~Hclk;

  ahb_apb3_bridge_if #(
    .DATA_W  (32),
    .ADDR_W  (32),
    .NUM_SLV (4)
  ) bus ();

  ahb_apb3_bridge #(
    .DATA_W  (32),
    .ADDR_W  (32),
    .NUM_SLV (4),
    .SEL_LSB (24)
  ) dut (
    .Hclk   (Hclk),
    .Hreset (Hreset),
    .bus    (bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_rdata = 32'h0;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  // One AHB transfer with an APB slave that waits `waits` cycles
  task automatic xfer(
    input string       tag,
    input logic [31:0] addr,
    input logic [2:0]  size,
    input logic        wr,
    input logic [31:0] wdata,
    input int          waits,
    input logic        err,
    input logic [31:0] rdata
  );
    int          boff, nb, cyc, en_cnt;
    int          setup_cnt, err0_cnt, exp_lat;
    bit          legal, seen, unstable;
    logic [3:0]  exp_strb, exp_sel, sel0, strb0;
    logic [31:0] addr0, wd0;
    logic        wr0;

    boff  = int'(addr % 4);
    nb    = 1 << size;
    legal = ((addr >> 24) < 4) && (size <= 2)
         && ((addr % nb) == 0);
    exp_strb = 4'h0;
    if (wr)
      for (int b = 0; b < 4; b++)
        if (b >= boff && b < boff + nb)
          exp_strb[b] = 1'b1;
    exp_sel = 4'(1 << (addr >> 24));
    if (!legal)
      exp_lat = 2;
    else
      exp_lat = 3 + waits + (wr ? 1 : 0)
              + (err ? 1 : 0);

    chk({tag, "_start_ready"}, bus.Hreadyout, 1);
    bus.Hreadyin = 1'b1;
    bus.Htrans   = 2'b10;
    bus.Haddr    = addr;
    bus.Hsize    = size;
    bus.Hwrite   = wr;
    tick();
    bus.Htrans = 2'b00;
    bus.Hwdata = wdata;
    bus.Haddr  = $urandom;

    cyc = 1; en_cnt = 0; setup_cnt = 0;
    err0_cnt = 0; seen = 0; unstable = 0;
    sel0 = 0; strb0 = 0; addr0 = 0;
    wd0 = 0; wr0 = 0;
    while (!bus.Hreadyout && cyc < 64) begin
      if (bus.Pselx != 0) begin
        if (!seen) begin
          seen  = 1;
          sel0  = bus.Pselx;
          addr0 = bus.Paddr;
          wr0   = bus.Pwrite;
          strb0 = bus.Pstrb;
          wd0   = bus.Pwdata;
        end else if ({bus.Pselx, bus.Paddr,
                      bus.Pwrite, bus.Pstrb,
                      bus.Pwdata} !==
                     {sel0, addr0, wr0,
                      strb0, wd0}) begin
          unstable = 1;
        end
        if (!bus.Penable) setup_cnt++;
      end
      if (bus.Penable) begin
        en_cnt++;
        bus.Pready  = (en_cnt > waits);
        bus.Pslverr = (en_cnt > waits) && err;
        bus.Prdata  = (en_cnt > waits)
                    ? rdata : $urandom;
      end else begin
        bus.Pready  = 1'b0;
        bus.Pslverr = 1'b0;
      end
      if (bus.Hresp == 2'b01) err0_cnt++;
      tick();
      cyc++;
    end
    bus.Pready  = 1'b0;
    bus.Pslverr = 1'b0;

    if (legal && !wr && !err) exp_rdata = rdata;

    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_hresp_end"}, bus.Hresp,
        (!legal || err) ? 1 : 0);
    chk({tag, "_hrdata"}, bus.Hrdata, exp_rdata);
    chk({tag, "_psel_off"}, bus.Pselx, 0);
    chk({tag, "_penable_off"}, bus.Penable, 0);
    chk({tag, "_err1_cycles"}, err0_cnt,
        (!legal || err) ? 1 : 0);
    chk({tag, "_setup_cycles"}, setup_cnt,
        legal ? 1 : 0);
    chk({tag, "_access_cycles"}, en_cnt,
        legal ? waits + 1 : 0);
    if (legal) begin
      chk({tag, "_pselx"}, sel0, exp_sel);
      chk({tag, "_paddr"}, addr0, addr);
      chk({tag, "_pwrite"}, wr0, wr);
      chk({tag, "_pstrb"}, strb0, exp_strb);
      chk({tag, "_stable"}, unstable, 0);
      if (wr) chk({tag, "_pwdata"}, wd0, wdata);
    end

    tick();
    chk({tag, "_after_ready"}, bus.Hreadyout, 1);
    chk({tag, "_after_okay"}, bus.Hresp, 0);
  endtask

  task automatic no_xfer(
    input string      tag,
    input logic [1:0] tr,
    input logic       rdy
  );
    bus.Hreadyin = rdy;
    bus.Htrans   = tr;
    bus.Haddr    = 32'h0100_0000;
    bus.Hsize    = 3'd2;
    bus.Hwrite   = 1'b0;
    tick();
    chk({tag, "_ready"}, bus.Hreadyout, 1);
    chk({tag, "_okay"}, bus.Hresp, 0);
    chk({tag, "_no_psel"}, bus.Pselx, 0);
    bus.Htrans   = 2'b00;
    bus.Hreadyin = 1'b1;
    tick();
    chk({tag, "_still_idle"}, bus.Pselx, 0);
  endtask

  initial begin
    int          slot;
    logic [31:0] a;
    logic [2:0]  sz;

    Hreset       = 1'b1;
    bus.Hreadyin = 1'b1;
    bus.Htrans   = 2'b00;
    bus.Hsize    = 3'd0;
    bus.Hwrite   = 1'b0;
    bus.Haddr    = 32'h0;
    bus.Hwdata   = 32'h0;
    bus.Prdata   = 32'h0;
    bus.Pready   = 1'b0;
    bus.Pslverr  = 1'b0;
    tick();
    tick();
    chk("rst_hreadyout", bus.Hreadyout, 1);
    chk("rst_hresp", bus.Hresp, 0);
    chk("rst_hrdata", bus.Hrdata, 0);
    chk("rst_pselx", bus.Pselx, 0);
    chk("rst_penable", bus.Penable, 0);
    chk("rst_pwrite", bus.Pwrite, 0);
    chk("rst_paddr", bus.Paddr, 0);
    chk("rst_pwdata", bus.Pwdata, 0);
    chk("rst_pstrb", bus.Pstrb, 0);
    Hreset = 1'b0;
    tick();

    xfer("rd_basic", 32'h0100_0004, 3'd2, 1'b0,
         32'h0, 0, 1'b0, 32'hCAFE_F00D);
    xfer("wr_waits", 32'h0000_0002, 3'd1, 1'b1,
         32'hBEEF_0000, 3, 1'b0, 32'h0);
    xfer("unmapped", 32'h0400_0000, 3'd2, 1'b0,
         32'h0, 0, 1'b0, 32'h1111_2222);
    xfer("rd_slverr", 32'h0300_0010, 3'd2, 1'b0,
         32'h0, 1, 1'b1, 32'hDEAD_BEEF);
    xfer("wr_slverr", 32'h0200_0001, 3'd0, 1'b1,
         32'h0000_AB00, 0, 1'b1, 32'h0);

    no_xfer("busy", 2'b01, 1'b1);
    no_xfer("idle", 2'b00, 1'b1);
    no_xfer("notready", 2'b10, 1'b0);
    xfer("misalign", 32'h0000_0001, 3'd2, 1'b0,
         32'h0, 0, 1'b0, 32'h5555_AAAA);
    xfer("oversize", 32'h0100_0000, 3'd3, 1'b1,
         32'h1234_5678, 0, 1'b0, 32'h0);

    // Abort a read in its access phase
    bus.Hreadyin = 1'b1;
    bus.Htrans   = 2'b10;
    bus.Haddr    = 32'h0200_0008;
    bus.Hsize    = 3'd2;
    bus.Hwrite   = 1'b0;
    tick();
    bus.Htrans = 2'b00;
    bus.Pready = 1'b0;
    for (int i = 0; i < 10 && !bus.Penable; i++)
      tick();
    chk("abort_in_access", bus.Penable, 1);
    Hreset = 1'b1;
    tick();
    Hreset = 1'b0;
    exp_rdata = 32'h0;
    chk("abort_pselx", bus.Pselx, 0);
    chk("abort_penable", bus.Penable, 0);
    chk("abort_ready", bus.Hreadyout, 1);
    chk("abort_hresp", bus.Hresp, 0);
    chk("abort_paddr", bus.Paddr, 0);
    chk("abort_hrdata", bus.Hrdata, 0);
    tick();
    chk("abort_no_late_err", bus.Hresp, 0);
    chk("abort_no_late_sel", bus.Pselx, 0);
    xfer("rd_after_abort", 32'h0200_0008, 3'd2,
         1'b0, 32'h0, 0, 1'b0, 32'h0BAD_F00D);

    for (int n = 0; n < 40; n++) begin
      slot = $urandom_range(0, 4);
      a    = (32'(slot) << 24)
           | ($urandom & 32'h00FF_FFFF);
      sz   = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 4) != 0)
        a = a & ~((32'd1 << sz) - 32'd1);
      xfer("rand", a, sz, 1'($urandom),
           $urandom, $urandom_range(0, 3),
           1'($urandom_range(0, 9) == 0),
           $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
